// File: rtl/shift_seq_pkg.sv
// Shared state encoding for the shift sequencer.
// Latency: n/a (constants only). Backpressure: n/a.
// Used by shift_sequencer; 2'b11 is an illegal encoding that the FSM recovers from.
package shift_seq_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

endpackage

// File: rtl/shift_tick_gen.sv
// Shift tick prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle.
// Latency: tick is combinational from the count; count updates on each enabled edge.
// Backpressure: enable low freezes the count in place; clear forces it back to zero.
module shift_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk_100MHz,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Button-driven run controller for the LED shift register (start/pause/resume/abort/preload).
// Latency: first shift TICK_DIV edges after start; strobe/done registered, one cycle wide.
// Backpressure: none; stop pauses, the prescaler holds. SHIFT_SEQ_ROTATE_EN enables LSB->MSB rotate.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int TICK_DIV = 25_000_000,
    parameter int STEPS_W  = 8
) (
    input  logic               clk_100MHz,
    input  logic               rst_n,
    input  logic               start_pulse,
    input  logic               stop_pulse,
    input  logic               load_pulse,
    input  logic [WIDTH-1:0]   load_value,
    input  logic               serial_in,
    input  logic               rotate,
    input  logic [STEPS_W-1:0] step_count,
    output logic [WIDTH-1:0]   parallel_out,
    output logic               shift_strobe,
    output logic               busy,
    output logic               done,
    output logic [ST_W-1:0]    state_out
);

    state_t             state_q, state_d;
    logic [STEPS_W-1:0] remaining;
    logic               tick;
    logic               shift_en;
    logic               load_en;
    logic               done_d;
    logic               arm;
    logic               in_bit;

`ifdef SHIFT_SEQ_ROTATE_EN
    assign in_bit = rotate ? parallel_out[0] : serial_in;
`else
    logic unused_rotate;
    assign unused_rotate = rotate;
    assign in_bit        = serial_in;
`endif

    // Idle (or illegal) keeps the prescaler at zero so every run starts with a full period.
    shift_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .enable     (state_q == ST_RUN),
        .clear      ((state_q != ST_RUN) && (state_q != ST_PAUSE)),
        .tick       (tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        load_en  = 1'b0;
        done_d   = 1'b0;
        arm      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_en = load_pulse;
                if (start_pulse && !stop_pulse) begin
                    state_d = ST_RUN;
                    arm     = 1'b1;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    shift_en = 1'b1;
                    if (remaining == STEPS_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                // Completion takes priority over a coincident stop.
                if (stop_pulse && !done_d) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                load_en = load_pulse;
                if (stop_pulse) begin
                    state_d = ST_IDLE;
                end else if (start_pulse) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            shift_strobe <= 1'b0;
            remaining    <= '0;
            parallel_out <= '0;
        end else begin
            state_q      <= state_d;
            busy         <= (state_d != ST_IDLE);
            done         <= done_d;
            shift_strobe <= shift_en;
            // remaining == 0 marks a free run; it is never decremented.
            if (arm) begin
                remaining <= step_count;
            end else if (shift_en && (remaining != '0)) begin
                remaining <= remaining - 1'b1;
            end
            if (load_en) begin
                parallel_out <= load_value;
            end else if (shift_en) begin
                parallel_out <= {in_bit, parallel_out[WIDTH-1:1]};
            end
        end
    end

    assign state_out = state_q;

endmodule
